// File: rtl/lsu_mem_port.sv
// Load/store initiator between the execute stage and a word-addressed unified memory.
// One request at a time: fault check at capture, read for loads and sub-word stores, write for stores.
module lsu_mem_port #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        mem_is_load,
    output logic        mem_is_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store_data,
    input  logic [31:0] mem_load_data
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] sdata_q, sdata_d;
    logic        accept;
    logic        req_fault;

    function automatic logic is_fault(input logic w, input logic [2:0] f, input logic [31:0] a);
        logic bad;
        bad = 1'b0;
        case (f)
            F3_B:         bad = 1'b0;
            F3_H:         bad = a[0];
            F3_W:         bad = (a[1:0] != 2'b00);
            F3_BU, F3_HU: bad = w;
            default:      bad = 1'b1;
        endcase
        if ((a >> (ADDR_W + 2)) != 32'd0) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'd0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [2:0] f, input logic [1:0] off);
        logic [31:0] m;
        m = word;
        case (f)
            F3_B: m[{off, 3'b000} +: 8] = wd[7:0];
            F3_H: begin
                if (off[1]) m[31:16] = wd[15:0];
                else        m[15:0]  = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    assign accept    = req && (state_q == S_IDLE);
    assign req_fault = is_fault(we, funct3, addr);

    // The read word is consumed straight off the memory port in RD: it is extended
    // into rdata for loads, or merged into the write word for sub-word stores.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        sdata_d = sdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    fault_d = req_fault;
                    maddr_d = {2'b00, addr[31:2]};
                    sdata_d = wdata;
                    if (req_fault) begin
                        state_d = S_RESP;
                        rdata_d = 32'd0;
                    end else if (we && funct3 == F3_W) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (we_q) begin
                    state_d = S_WR;
                    sdata_d = store_merge(mem_load_data, wdata_q, f3_q, off_q);
                end else begin
                    state_d = S_RESP;
                    rdata_d = load_extend(mem_load_data, f3_q, off_q);
                end
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
            maddr_q <= 32'd0;
            sdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            sdata_q <= sdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            f3_q    <= funct3;
            off_q   <= addr[1:0];
            wdata_q <= wdata;
        end
    end

    // Strobes decode directly from state so an asynchronous reset removes them at once.
    assign ready          = (state_q == S_IDLE);
    assign done           = (state_q == S_RESP);
    assign fault          = done && fault_q;
    assign mem_is_load    = (state_q == S_RD);
    assign mem_is_store   = (state_q == S_WR);
    assign rdata          = rdata_q;
    assign mem_addr       = maddr_q;
    assign mem_store_data = sdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed testbench for lsu_mem_port with a behavioural word memory.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready, done, fault, mem_is_load, mem_is_store;
    logic [31:0] rdata, mem_addr, mem_store_data, mem_load_data;

    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_idx = 12'd0;
    logic [31:0] pl_val = 32'd0;

    int n_cmp = 0;
    int n_err = 0;

    logic        o_done [1:6];
    logic        o_ld   [1:6];
    logic        o_st   [1:6];
    logic        o_flt  [1:6];
    logic        o_rdy  [1:6];
    logic [31:0] o_rdata[1:6];
    logic [31:0] o_sdata[1:6];
    logic [31:0] o_maddr[1:6];
    logic        o_rdy0;

    lsu_mem_port #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .fault(fault),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store), .mem_addr(mem_addr),
        .mem_store_data(mem_store_data), .mem_load_data(mem_load_data)
    );

    always #5 clk = ~clk;

    assign mem_load_data = mem[mem_addr[11:0]];

    always @(posedge clk) begin
        if (mem_is_store) mem[mem_addr[11:0]] <= mem_store_data;
        else if (pl_en)   mem[pl_idx] <= pl_val;
    end

    task automatic preload(input logic [11:0] idx, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request and record outputs for the following n cycles (index 1 = cycle T+1).
    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input int n);
        @(negedge clk);
        o_rdy0 = ready;
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) req = 1'b0;
            o_done[i] = done; o_ld[i] = mem_is_load; o_st[i] = mem_is_store;
            o_flt[i] = fault; o_rdy[i] = ready; o_rdata[i] = rdata;
            o_sdata[i] = mem_store_data; o_maddr[i] = mem_addr;
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", ready); end
        n_cmp++; if ({done, fault, mem_is_load, mem_is_store} !== 4'b0000) begin n_err++; $display("FAIL rst_strobes got %b want 0000", {done, fault, mem_is_load, mem_is_store}); end
        n_cmp++; if ({rdata, mem_addr, mem_store_data} !== 96'd0) begin n_err++; $display("FAIL rst_data got %h want 0", {rdata, mem_addr, mem_store_data}); end
        @(negedge clk); rst_n = 1'b1;
        preload(12'd4, 32'hDEADBEEF);
        preload(12'd0, 32'h12345678);
        run_req(1'b0, 3'b010, 32'h10, 32'd0, 3);
        // reset while the load is in RD
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
        @(posedge clk); #2; req = 1'b0;
        n_cmp++; if (mem_is_load !== 1'b1) begin n_err++; $display("FAIL midrd_load got %b want 1", mem_is_load); end
        #1 rst_n = 1'b0; #1;
        n_cmp++; if (mem_is_load !== 1'b0) begin n_err++; $display("FAIL midrd_load_drop got %b want 0", mem_is_load); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midrd_ready got %b want 1", ready); end
        n_cmp++; if ({done, fault, mem_is_store} !== 3'b000) begin n_err++; $display("FAIL midrd_strobes got %b want 000", {done, fault, mem_is_store}); end
        n_cmp++; if ({rdata, mem_addr, mem_store_data} !== 96'd0) begin n_err++; $display("FAIL midrd_data got %h want 0", {rdata, mem_addr, mem_store_data}); end
        @(negedge clk); rst_n = 1'b1;
        run_req(1'b0, 3'b010, 32'h0, 32'd0, 3);
        n_cmp++; if ({o_done[1], o_done[2]} !== 2'b01) begin n_err++; $display("FAIL post_rst_done got %b want 01", {o_done[1], o_done[2]}); end
        n_cmp++; if (o_rdata[2] !== 32'h12345678) begin n_err++; $display("FAIL post_rst_rdata got %h want 12345678", o_rdata[2]); end
    endtask

    task automatic test_lw();
        preload(12'd4, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 32'h10, 32'd0, 3);
        n_cmp++; if (o_rdy0 !== 1'b1) begin n_err++; $display("FAIL lw_ready got %b want 1", o_rdy0); end
        n_cmp++; if (o_maddr[1] !== 32'd4) begin n_err++; $display("FAIL lw_maddr got %h want 4", o_maddr[1]); end
        n_cmp++; if ({o_ld[1], o_st[1], o_done[1]} !== 3'b100) begin n_err++; $display("FAIL lw_t1 got %b want 100", {o_ld[1], o_st[1], o_done[1]}); end
        n_cmp++; if ({o_ld[2], o_st[2], o_done[2], o_flt[2]} !== 4'b0010) begin n_err++; $display("FAIL lw_t2 got %b want 0010", {o_ld[2], o_st[2], o_done[2], o_flt[2]}); end
        n_cmp++; if (o_rdata[2] !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata got %h want deadbeef", o_rdata[2]); end
        n_cmp++; if ({o_done[3], o_rdy[3]} !== 2'b01) begin n_err++; $display("FAIL lw_t3 got %b want 01", {o_done[3], o_rdy[3]}); end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  fs [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] as [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11};
        logic [31:0] es [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F};
        preload(12'd4, 32'h80FF7F01);
        for (int k = 0; k < 5; k++) begin
            run_req(1'b0, fs[k], as[k], 32'd0, 3);
            n_cmp++; if ({o_done[2], o_flt[2]} !== 2'b10) begin n_err++; $display("FAIL ld%0d_done got %b want 10", k, {o_done[2], o_flt[2]}); end
            n_cmp++; if (o_rdata[2] !== es[k]) begin n_err++; $display("FAIL ld%0d_rdata f3=%b a=%h got %h want %h", k, fs[k], as[k], o_rdata[2], es[k]); end
        end
    endtask

    task automatic test_subword_stores();
        preload(12'd4, 32'h11223344);
        run_req(1'b1, 3'b000, 32'h11, 32'h000000AA, 4);
        n_cmp++; if ({o_ld[1], o_st[1]} !== 2'b10) begin n_err++; $display("FAIL sb_t1 got %b want 10", {o_ld[1], o_st[1]}); end
        n_cmp++; if ({o_ld[2], o_st[2], o_done[2]} !== 3'b010) begin n_err++; $display("FAIL sb_t2 got %b want 010", {o_ld[2], o_st[2], o_done[2]}); end
        n_cmp++; if (o_sdata[2] !== 32'h1122AA44) begin n_err++; $display("FAIL sb_data got %h want 1122aa44", o_sdata[2]); end
        n_cmp++; if ({o_done[3], o_flt[3]} !== 2'b10) begin n_err++; $display("FAIL sb_done got %b want 10", {o_done[3], o_flt[3]}); end
        n_cmp++; if (o_rdata[3] !== 32'h0000007F) begin n_err++; $display("FAIL sb_rdata_hold got %h want 0000007f", o_rdata[3]); end
        n_cmp++; if (mem[4] !== 32'h1122AA44) begin n_err++; $display("FAIL sb_mem got %h want 1122aa44", mem[4]); end
        preload(12'd4, 32'h11223344);
        run_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 4);
        n_cmp++; if (o_sdata[2] !== 32'hBEEF3344 || o_st[2] !== 1'b1) begin n_err++; $display("FAIL sh_data got %h st=%b want beef3344 st=1", o_sdata[2], o_st[2]); end
        n_cmp++; if (o_done[3] !== 1'b1) begin n_err++; $display("FAIL sh_done got %b want 1", o_done[3]); end
        n_cmp++; if (mem[4] !== 32'hBEEF3344) begin n_err++; $display("FAIL sh_mem got %h want beef3344", mem[4]); end
    endtask

    task automatic test_sw();
        run_req(1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 3);
        n_cmp++; if ({o_ld[1], o_st[1], o_maddr[1]} !== {2'b01, 32'd5}) begin n_err++; $display("FAIL sw_t1 got %b %h want 01 5", {o_ld[1], o_st[1]}, o_maddr[1]); end
        n_cmp++; if (o_sdata[1] !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw_data got %h want cafef00d", o_sdata[1]); end
        n_cmp++; if ({o_done[2], o_st[2]} !== 2'b10) begin n_err++; $display("FAIL sw_done got %b want 10", {o_done[2], o_st[2]}); end
        n_cmp++; if (mem[5] !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw_mem got %h want cafef00d", mem[5]); end
    endtask

    task automatic test_faults();
        logic        ws [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  fs [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
        logic [31:0] as [4] = '{32'h102, 32'h101, 32'h4000, 32'h10};
        for (int k = 0; k < 4; k++) begin
            run_req(1'b0, 3'b010, 32'h0, 32'd0, 2);
            run_req(ws[k], fs[k], as[k], 32'h55555555, 3);
            n_cmp++; if ({o_done[1], o_flt[1]} !== 2'b11) begin n_err++; $display("FAIL flt%0d_done got %b want 11", k, {o_done[1], o_flt[1]}); end
            n_cmp++; if (o_rdata[1] !== 32'd0) begin n_err++; $display("FAIL flt%0d_rdata got %h want 0", k, o_rdata[1]); end
            n_cmp++; if ({o_ld[1], o_st[1], o_ld[2], o_st[2], o_done[2]} !== 5'b00000) begin n_err++; $display("FAIL flt%0d_strobes got %b want 00000", k, {o_ld[1], o_st[1], o_ld[2], o_st[2], o_done[2]}); end
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            o_done[i] = done; o_ld[i] = mem_is_load; o_rdy[i] = ready;
            if (i == 4) req = 1'b0;
        end
        for (int i = 1; i <= 4; i++) if (o_done[i]) ndone++;
        n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL b2b_single_done got %0d want 1", ndone); end
        n_cmp++; if ({o_done[2], o_done[3], o_rdy[3]} !== 3'b101) begin n_err++; $display("FAIL b2b_resp_idle got %b want 101", {o_done[2], o_done[3], o_rdy[3]}); end
        n_cmp++; if ({o_ld[4], o_done[5]} !== 2'b11) begin n_err++; $display("FAIL b2b_second got %b want 11", {o_ld[4], o_done[5]}); end
    endtask

    task automatic test_reset_during_wr();
        int seen;
        seen = 0;
        preload(12'd4, 32'h11223344);
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h11; wdata = 32'h000000AA;
        @(posedge clk); #2; req = 1'b0;
        @(posedge clk); #2;
        n_cmp++; if ({mem_is_store, mem_store_data} !== {1'b1, 32'h1122AA44}) begin n_err++; $display("FAIL rstwr_pre got %b %h want 1 1122aa44", mem_is_store, mem_store_data); end
        #1 rst_n = 1'b0; #1;
        n_cmp++; if (mem_is_store !== 1'b0) begin n_err++; $display("FAIL rstwr_store_drop got %b want 0", mem_is_store); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); if (done) seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); if (done) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstwr_done got %0d want 0", seen); end
        n_cmp++; if (mem[4] !== 32'h11223344) begin n_err++; $display("FAIL rstwr_mem got %h want 11223344", mem[4]); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_subword_loads();
        test_subword_stores();
        test_sw();
        test_faults();
        test_back_to_back();
        test_reset_during_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator sitting between the CPU execute stage and the unified word-addressed instruction/data memory. Accepts one RV32I load or store request at a time, drives the memory's `is_load`/`is_store`/`mem_addr`/`store_data` port and consumes `load_data`. Performs byte/halfword extraction with sign/zero extension for loads and read-modify-write merging for sub-word stores. Pipeline stalls on `ready` and resumes on `done`.

## Interface

Parameters:
- `ADDR_W`, default 12: log2 of memory depth in 32-bit words. Byte addresses with `addr[31:ADDR_W+2] != 0` are out of range.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; accepted only in a cycle where `ready=1`.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `addr`  in  32  byte address; sampled with `req`.
- `wdata`  in  32  store data, right-aligned; sampled with `req`.
- `ready`  out  1  1 in IDLE only.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; updated in the `done` cycle, held until the next `done`.
- `fault`  out  1  valid with `done`. 1 = request rejected with no memory access.
- `mem_is_load`  out  1  memory read enable.
- `mem_is_store`  out  1  memory write enable; memory writes on the rising edge of `clk` when 1.
- `mem_addr`  out  32  word index, `{2'b00, addr[31:2]}` of the captured request.
- `mem_store_data`  out  32  full word to write.
- `mem_load_data`  in  32  combinational read data for `mem_addr`.

## Operation

Request capture:
- On `req && ready`, the block registers `we`, `funct3`, `addr` and `wdata`.
- Inputs are ignored in all other cycles.

Fault check (at capture):
- Any of the following sets fault:
  - illegal `funct3` (011, 110, 111, or 100/101 with `we=1`);
  - H with `addr[0]=1`;
  - W with `addr[1:0]!=0`;
  - out-of-range address.
- Fault path goes directly to RESP with `fault=1` and `rdata=0`.
- No memory strobe is asserted on the fault path.

FSM states:
- IDLE:
  - `ready=1`.
  - `req` with fault goes to RESP.
  - SW goes to WR.
  - Any load, SB or SH goes to RD.
- RD:
  - `mem_is_load=1`; register `mem_load_data` into `rword`.
  - A load goes to RESP.
  - SB/SH goes to WR.
- WR:
  - `mem_is_store=1`. `mem_store_data` is:
    - SW: `wdata`;
    - SH: `rword` with halfword `addr[1]` replaced by `wdata[15:0]`;
    - SB: `rword` with byte `addr[1:0]` replaced by `wdata[7:0]`.
  - Goes to RESP.
- RESP:
  - `done=1`, `ready=0`.
  - For a load, `rdata` is taken from the selected lane of `rword`:
    - B/H are sign-extended;
    - BU/HU are zero-extended;
    - W is passed through.
  - For a store, `rdata` is unchanged.
  - Goes to IDLE.

Other rules:
- `mem_is_load` and `mem_is_store` are never both 1.
- Each is asserted for exactly one cycle per access.
- `mem_addr` and `mem_store_data` are registered and stable through RD/WR.

## Timing

Request accepted at edge T. Latencies:
- Fault: `done` in cycle T+1.
- Load: RD in T+1, `done` in T+2.
- SW: WR in T+1, `done` in T+2.
- SB/SH: RD in T+1, WR in T+2, `done` in T+3.

Back-to-back: the next request is accepted at the edge ending RESP+1, i.e. minimum issue interval = latency + 1.

Reset (`rst_n=0`), applied asynchronously:
- State goes to IDLE, so `ready=1`.
- `done`, `fault`, `mem_is_load`, `mem_is_store` are 0.
- `rdata`, `mem_addr`, `mem_store_data` are 0.

Reset mid-operation:
- `mem_is_store` drops immediately and the pending write is lost; no partial merge is written.
- No `done` is produced for the aborted request.

`req` held high across RESP is not re-accepted until IDLE.

## Test plan

- Reset: assert `rst_n=0` mid-RD -> `mem_is_load=0` immediately, `ready=1`, all outputs 0. Release reset, then LW `0x0` -> normal `done` at T+2.
- LW `addr=0x10`, word 4 = `0xDEADBEEF` -> `mem_addr=4`, `mem_is_load` only at T+1, `done` at T+2, `rdata=0xDEADBEEF`, `fault=0`.
- Word 4 = `0x80FF7F01`:
  - LB `0x13` -> `0xFFFFFF80`;
  - LBU `0x13` -> `0x00000080`;
  - LH `0x12` -> `0xFFFF80FF`;
  - LHU `0x10` -> `0x00007F01`;
  - LB `0x11` -> `0x0000007F`.
- Word 4 = `0x11223344`:
  - SB `0x11`, `wdata=0x000000AA` -> RD at T+1; WR at T+2 with `mem_store_data=0x1122AA44`; `done` at T+3.
  - SH `0x12`, `wdata=0x0000BEEF` -> `0xBEEF3344`.
- Faults -> each gives `done` at T+1, `fault=1`, `rdata=0`, no `mem_is_load`/`mem_is_store`:
  - LW `0x102`;
  - SH `0x101`;
  - LW `0x4000` with `ADDR_W=12`;
  - store with `funct3=100`.
- Reset asserted during WR of SB `0x11` -> `mem_is_store` falls before the next edge, word 4 stays `0x11223344`, no `done` pulse.
